// File: rtl/fbcpu_pkg.sv
// Shared FBCPU definitions: loader state encoding and default core widths.
package fbcpu_pkg;

  localparam int FBCPU_ADDR_W = 6;
  localparam int FBCPU_DATA_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } fbcpu_state_e;

endpackage

// File: rtl/fbcpu_ram_mux.sv
// RAM port select: the core owns the port when sel_core_i is high,
// otherwise the loader side drives it. Purely combinational so a later
// debug port can be added as another source.
module fbcpu_ram_mux #(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic          sel_core_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic          ldr_wr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic          cpu_wr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_wr_o,
  output logic [DW-1:0] ram_wdata_o
);

  // Two-way select, no registers in either path.
  always_comb begin
    if (sel_core_i) begin
      ram_addr_o  = cpu_addr_i;
      ram_wr_o    = cpu_wr_i;
      ram_wdata_o = cpu_wdata_i;
    end else begin
      ram_addr_o  = ldr_addr_i;
      ram_wr_o    = ldr_wr_i;
      ram_wdata_o = ldr_wdata_i;
    end
  end

endmodule

// File: rtl/fbcpu_boot_loader.sv
// FBCPU boot loader: holds the core in reset, streams an image into the
// program/data RAM, then hands the RAM port to the core and releases it.
// Optional trailer checksum check: define FBCPU_LOADER_CHECKSUM_EN.
module fbcpu_boot_loader
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FBCPU_ADDR_W,
  parameter int DATA_WIDTH    = FBCPU_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   load_len,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     cpu_rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic                     cpu_wr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_wr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

`ifdef FBCPU_LOADER_CHECKSUM_EN
  localparam fbcpu_state_e LOAD_NEXT = CHECK;
`else
  localparam fbcpu_state_e LOAD_NEXT = RUN;
`endif

  fbcpu_state_e           state_q, state_d;
  logic [ADDRESS_WIDTH:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH:0] len_q, len_d;
  logic                   cpu_rst_q, cpu_rst_d;
`ifdef FBCPU_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  csum_q, csum_d;
`endif

  logic                     beat;
  logic                     len_ok;
  logic                     ldr_wr;
  logic [ADDRESS_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0]    ldr_wdata;

  assign beat   = s_valid & s_ready;
  assign len_ok = (load_len <= DEPTH);

  // State and datapath registers; cpu_rst is registered so the core only
  // leaves reset one edge after RUN is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      cpu_rst_q <= 1'b1;
`ifdef FBCPU_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef FBCPU_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state: start is honoured in IDLE/RUN/ERROR only; LOAD ends on the
  // beat that fills the last word (or at once for an empty image).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef FBCPU_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, ERROR, RUN: begin
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            len_d   = load_len;
            cnt_d   = '0;
`ifdef FBCPU_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            state_d = ERROR;
          end
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          state_d = LOAD_NEXT;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
`ifdef FBCPU_LOADER_CHECKSUM_EN
          csum_d = csum_q + s_data;
`endif
          if (cnt_q == len_q - 1'b1) state_d = LOAD_NEXT;
        end
      end
`ifdef FBCPU_LOADER_CHECKSUM_EN
      CHECK: begin
        if (beat) state_d = (s_data == csum_q) ? RUN : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Core runs only while we stay in RUN; leaving RUN re-asserts reset
    // on the same edge as the state change.
    cpu_rst_d = !((state_q == RUN) && (state_d == RUN));
  end

  // Outputs decoded from the current state; loader drives the RAM only on
  // an accepted beat, otherwise the port idles at zero.
  always_comb begin
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    ldr_wr    = 1'b0;
    ldr_addr  = '0;
    ldr_wdata = '0;
    case (state_q)
      LOAD: begin
        busy    = 1'b1;
        s_ready = (len_q != '0);
        if (s_valid && (len_q != '0)) begin
          ldr_wr    = 1'b1;
          ldr_addr  = cnt_q[ADDRESS_WIDTH-1:0];
          ldr_wdata = s_data;
        end
      end
      CHECK: begin
        busy    = 1'b1;
        s_ready = 1'b1;
      end
      RUN:     done = 1'b1;
      ERROR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rst = cpu_rst_q;

  fbcpu_ram_mux #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_mux (
    .sel_core_i  (state_q == RUN),
    .ldr_addr_i  (ldr_addr),
    .ldr_wr_i    (ldr_wr),
    .ldr_wdata_i (ldr_wdata),
    .cpu_addr_i  (cpu_mar),
    .cpu_wr_i    (cpu_wr),
    .cpu_wdata_i (cpu_wdata),
    .ram_addr_o  (ram_addr),
    .ram_wr_o    (ram_wr),
    .ram_wdata_o (ram_wdata)
  );

endmodule

// File: tb/tb_fbcpu_boot_loader.sv
// Bench for fbcpu_boot_loader: a phase/words-remaining model predicts every
// output each cycle, directed tests pin the model with literal values.
module tb_fbcpu_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] load_len = '0;
  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, cpu_rst, ram_wr, busy, done, err;
  logic [5:0] cpu_mar = '0;
  logic       cpu_wr = 1'b0;
  logic [9:0] cpu_wdata = '0;
  logic [5:0] ram_addr;
  logic [9:0] ram_wdata;

  fbcpu_boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_rst(cpu_rst), .cpu_mar(cpu_mar), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 check, 3 run, 4 error.
  int         m_ph = 0;
  int         m_left = 0;
  int         m_idx = 0;
  int         m_sum = 0;
  logic       m_rst = 1'b1;
  logic [9:0] dut_ram [64];
  int         wr_cnt = 0;
  int         last_addr = -1;

  // Compare DUT against the model mid-cycle, then advance the model with
  // the inputs the DUT will sample on the coming edge.
  always @(negedge clk) begin
    logic       e_rdy, e_beat, e_wr;
    logic [5:0] e_addr;
    logic [9:0] e_wd;
    int         nph;
    if (!rst) begin
      m_ph = 0; m_rst = 1'b1;
      chk("rst.cpu_rst", cpu_rst, 1); chk("rst.s_ready", s_ready, 0);
      chk("rst.busy", busy, 0); chk("rst.done", done, 0); chk("rst.err", err, 0);
      chk("rst.ram_wr", ram_wr, 0); chk("rst.ram_addr", ram_addr, 0);
      chk("rst.ram_wdata", ram_wdata, 0);
    end else begin
      e_rdy  = (m_ph == 1 && m_left > 0) || m_ph == 2;
      e_beat = e_rdy && s_valid;
      e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (m_ph == 3) begin
        e_wr = cpu_wr; e_addr = cpu_mar; e_wd = cpu_wdata;
      end else if (m_ph == 1 && e_beat) begin
        e_wr = 1'b1; e_addr = 6'(m_idx); e_wd = s_data;
      end
      chk("s_ready", s_ready, e_rdy);
      chk("busy", busy, m_ph == 1 || m_ph == 2);
      chk("done", done, m_ph == 3);
      chk("err", err, m_ph == 4);
      chk("cpu_rst", cpu_rst, m_rst);
      chk("ram_wr", ram_wr, e_wr);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wd);
      if (ram_wr === 1'b1) begin
        dut_ram[ram_addr] = ram_wdata;
        wr_cnt++;
        last_addr = int'(ram_addr);
      end
      nph = m_ph;
      case (m_ph)
        0, 3, 4: if (start) begin
          if (load_len <= 7'd64) begin
            nph = 1; m_left = int'(load_len); m_idx = 0; m_sum = 0;
          end else nph = 4;
        end
        1: begin
          if (m_left == 0) nph = 1;
          if (e_beat) begin
            m_sum = (m_sum + int'(s_data)) % 1024;
            m_idx++; m_left--;
          end
          if (m_left == 0) begin
`ifdef FBCPU_LOADER_CHECKSUM_EN
            nph = 2;
`else
            nph = 3;
`endif
          end
        end
        2: if (e_beat) nph = (int'(s_data) == m_sum) ? 3 : 4;
        default: nph = 0;
      endcase
      m_rst = !(m_ph == 3 && nph == 3);
      m_ph  = nph;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [6:0] n);
    start = 1'b1; load_len = n; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [9:0] w);
    s_valid = 1'b1; s_data = w; tick(); s_valid = 1'b0;
  endtask

  task automatic trailer(input logic [9:0] sum);
`ifdef FBCPU_LOADER_CHECKSUM_EN
    send(sum);
`else
    s_data = sum;
`endif
  endtask

  initial begin
    int sum;
    logic [9:0] w;
    // Reset state
    repeat (2) tick();
    chk("t0.cpu_rst", cpu_rst, 1); chk("t0.busy", busy, 0);
    chk("t0.done", done, 0); chk("t0.s_ready", s_ready, 0);
    rst = 1'b1; tick();

    // T1: three-word load, then hand-over to the core
    wr_cnt = 0; do_start(7'd3);
    chk("t1.busy", busy, 1); chk("t1.cpu_rst_load", cpu_rst, 1);
    send(10'h040); send(10'h181); send(10'h200); trailer(10'h3C1);
    chk("t1.done", done, 1); chk("t1.cpu_rst_entry", cpu_rst, 1);
    chk("t1.wr_cnt", wr_cnt, 3);
    chk("t1.ram0", dut_ram[0], 10'h040); chk("t1.ram1", dut_ram[1], 10'h181);
    chk("t1.ram2", dut_ram[2], 10'h200);
    tick(); chk("t1.cpu_rst_fall", cpu_rst, 0);
    cpu_mar = 6'd0; #1 chk("t1.mar0", ram_addr, 0);
    cpu_mar = 6'd7; #1 chk("t1.mar7", ram_addr, 7);
    cpu_mar = 6'd0;

    // T2: gappy valid 1-0-0-1-1, start while busy ignored
    tick(); wr_cnt = 0; do_start(7'd3);
    send(10'h011);
    tick();
    start = 1'b1; load_len = 7'd65; tick(); start = 1'b0;
    chk("t2.busy_after_start", busy, 1);
    send(10'h022); send(10'h033); trailer(10'h066);
    chk("t2.done", done, 1); chk("t2.wr_cnt", wr_cnt, 3);
    chk("t2.last_addr", last_addr, 2); chk("t2.ram1", dut_ram[1], 10'h022);

    // T3: over-length image errors out, then a full 64-word image
    wr_cnt = 0; do_start(7'd65);
    chk("t3.err", err, 1); chk("t3.cpu_rst", cpu_rst, 1);
    tick(); tick();
    chk("t3.err_hold", err, 1); chk("t3.no_wr", wr_cnt, 0);
    do_start(7'd64);
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      w = 10'((i * 7 + 3) & 10'h3FF);
      sum = sum + int'(w);
      if (i == 63) begin start = 1'b1; load_len = 7'd1; end
      send(w);
      start = 1'b0;
    end
    trailer(10'(sum));
    chk("t3.done", done, 1); chk("t3.wr_cnt", wr_cnt, 64);
    chk("t3.last_addr", last_addr, 63); chk("t3.ram63", dut_ram[63], 10'h1BC);

    // T4: core write in RUN, then reload while the core keeps writing
    tick();
    cpu_mar = 6'd10; cpu_wr = 1'b1; cpu_wdata = 10'h155; tick();
    chk("t4.core_wr", dut_ram[10], 10'h155);
    start = 1'b1; load_len = 7'd1; tick(); start = 1'b0;
    cpu_wdata = 10'h0F0;
    chk("t4.busy", busy, 1); chk("t4.cpu_rst", cpu_rst, 1);
    chk("t4.ram_wr_blocked", ram_wr, 0);
    send(10'h2AA); trailer(10'h2AA);
    cpu_wr = 1'b0;
    chk("t4.done", done, 1); chk("t4.ram0", dut_ram[0], 10'h2AA);
    chk("t4.ram10", dut_ram[10], 10'h155);

    // T5: reset asserted during the second of four beats
    tick(); wr_cnt = 0; do_start(7'd4);
    send(10'h101);
    s_valid = 1'b1; s_data = 10'h102;
    #2 rst = 1'b0;
    #1;
    chk("t5.busy", busy, 0); chk("t5.s_ready", s_ready, 0);
    chk("t5.ram_wr", ram_wr, 0); chk("t5.cpu_rst", cpu_rst, 1);
    chk("t5.done", done, 0); chk("t5.err", err, 0);
    s_valid = 1'b0;
    tick(); rst = 1'b1; tick();
    chk("t5.idle_busy", busy, 0); chk("t5.idle_done", done, 0);
    chk("t5.idle_err", err, 0); chk("t5.wr_cnt", wr_cnt, 1);

    // T6: empty image
    wr_cnt = 0; do_start(7'd0);
    chk("t6.busy", busy, 1); chk("t6.s_ready", s_ready, 0);
    tick(); trailer(10'h000);
    chk("t6.done", done, 1); chk("t6.wr_cnt", wr_cnt, 0);

`ifdef FBCPU_LOADER_CHECKSUM_EN
    // T7: trailer checksum accept / reject (0x3FF + 0x002 wraps to 0x001)
    tick(); do_start(7'd2);
    send(10'h3FF); send(10'h002); send(10'h001);
    chk("t7.good_done", done, 1);
    do_start(7'd2);
    send(10'h3FF); send(10'h002); send(10'h002);
    chk("t7.bad_err", err, 1); chk("t7.bad_cpu_rst", cpu_rst, 1);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fbcpu_boot_loader.md
Name: fbcpu_boot_loader

Overview:
- Sequences the FBCPU core: holds it in reset, streams a program image into the shared 64x10 program/data RAM, then hands the RAM port to the core and releases it.
- Sits between the core's memory port (MAR/RAMWr/MDRIn/MDROut) and the RAM.
- Owns the core's reset line and the RAM port mux.

Parameters:
- ADDRESS_WIDTH, 6, RAM address width; RAM depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 10, RAM/instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  pulse: begin a load; accepted in IDLE, RUN and ERROR.
- load_len  input  ADDRESS_WIDTH+1  number of image words; sampled on the start cycle.
- s_data  input  DATA_WIDTH  image word.
- s_valid  input  1  image word valid.
- s_ready  output  1  loader accepts a word.
- cpu_rst  output  1  active-high synchronous reset to the core, registered.
- cpu_mar  input  ADDRESS_WIDTH  core address.
- cpu_wr  input  1  core write enable.
- cpu_wdata  input  DATA_WIDTH  core write data.
- ram_addr  output  ADDRESS_WIDTH  RAM address.
- ram_wr  output  1  RAM write enable.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- busy  output  1  high in LOAD/CHECK.
- done  output  1  high in RUN.
- err  output  1  high in ERROR.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; word counter=0; len register=0; checksum=0.
  - cpu_rst=1. s_ready, busy, done, err=0.
  - ram_addr/ram_wr/ram_wdata=0.
- IDLE:
  - cpu_rst=1; RAM port driven 0.
  - start with load_len <= 2**ADDRESS_WIDTH: latch len, clear counter and checksum, go to LOAD.
  - start with load_len > 2**ADDRESS_WIDTH: go to ERROR.
- LOAD:
  - s_ready=1 (combinational from state).
  - Each beat (s_valid & s_ready) writes the same cycle: ram_wr=1, ram_addr=counter[ADDRESS_WIDTH-1:0], ram_wdata=s_data. Counter then increments.
  - After the beat with counter==len-1: go to RUN (or to CHECK with CHECKSUM_EN).
  - len==0: leave LOAD on the next clock with no writes.
  - s_valid low: stall indefinitely; no timeout.
- RUN:
  - ram_addr=cpu_mar, ram_wr=cpu_wr, ram_wdata=cpu_wdata. Pass-through, zero latency, no registers in the path.
  - cpu_rst is registered: it is 0 from the first edge after entering RUN, so the core starts fetching at PC=0 one cycle after RUN entry.
- ERROR:
  - cpu_rst=1, err=1; RAM port 0.
  - Exit only via start (same rule as IDLE) or rst.
- start while busy (LOAD/CHECK): ignored.
- start in RUN: cpu_rst reasserts on the next edge; RAM port is released from the core in the same cycle as the state change; the new load proceeds normally.
- Simultaneous start and the last LOAD beat: the beat completes; start is ignored.
- rst mid-load: immediate return to IDLE. Partial RAM contents are not cleared.
- Core writes are never passed to the RAM outside RUN.

Optional Feature:
- Macro: FBCPU_LOADER_CHECKSUM_EN.
- Defined:
  - LOAD accumulates checksum = sum of accepted words mod 2**DATA_WIDTH.
  - After the len words, state CHECK takes one more beat (s_ready=1, no RAM write).
  - Beat equals checksum: go to RUN. Otherwise: go to ERROR.
  - len==0: expected checksum is 0.
- Undefined: no CHECK state, no trailer beat, checksum register absent.

Decomposition:
- Shared package fbcpu_pkg:
  - state encoding constants: IDLE=0, LOAD=1, CHECK=2, RUN=3, ERROR=4 (3-bit).
  - FBCPU_ADDR_W=6, FBCPU_DATA_W=10.
- One sub-module: fbcpu_ram_mux, the combinational port select between loader and core, so it can be reused by a later debug port.

Test Plan:
- Reset release, start, load_len=3, words 0x040,0x181,0x200 → RAM[0..2] written on three handshake cycles; done=1; cpu_rst falls one cycle after RUN entry; first core MAR=0 reaches ram_addr.
- s_valid toggled 1-0-0-1-1 with load_len=3 → exactly 3 writes, addresses 0,1,2; no write while s_valid=0.
- load_len=65 → err=1, cpu_rst=1, no RAM write. Subsequent start with load_len=64 → 64 writes, last at address 63, then RUN.
- In RUN, core writes 0x155 to address 10; then start with load_len=1 → cpu_wr ignored after the state change; RAM[0]=new word; cpu_rst high during LOAD.
- rst pulled low during the second of four beats → outputs at reset values immediately; busy=0; after release, state is IDLE.
- CHECKSUM_EN, words 0x3FF,0x002 with trailer 0x001 → RUN. Same words with trailer 0x002 → ERROR, err=1.
